// File: rtl/core_pkg.sv
// Shared integer-core types: ALU opcodes, flag indices, stage bundle.
// Define ALU_FLAGS_EN to build alu_pipe with the NZCV flag output.
package core_pkg;

    localparam int LOG2_PREGS = 6;
    localparam int CORE_XLEN  = 32;
    localparam int CORE_ROB_W = 6;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_ORR = 4'd4,
        ALU_EOR = 4'd5,
        ALU_NEG = 4'd6,
        ALU_CMP = 4'd7,
        ALU_LSL = 4'd8,
        ALU_LSR = 4'd9,
        ALU_ASR = 4'd10,
        ALU_MOV = 4'd11
    } alu_op_e;

    // Bit positions inside the 4-bit NZCV vector
    localparam int ALU_FLAG_V = 0;
    localparam int ALU_FLAG_C = 1;
    localparam int ALU_FLAG_Z = 2;
    localparam int ALU_FLAG_N = 3;

    // Stage bundle at the default core widths; alu_pipe
    // re-declares it locally sized from its own parameters.
    typedef struct packed {
        logic                    valid;
        logic                    wr_en;
        logic [LOG2_PREGS-1:0]   dst_tag;
        logic [CORE_ROB_W-1:0]   rob_tag;
        logic [CORE_XLEN-1:0]    value;
        logic [3:0]              flags;
    } alu_stage_t;

endpackage

// File: rtl/alu_exec_comb.sv
// Pure combinational ALU op evaluator.
// NZCV flag logic is built only when ALU_FLAGS_EN is defined.
module alu_exec_comb
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e          op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  value,
    output logic             wr_en
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]       flags
`endif
);

    localparam int SW = $clog2(XLEN);
    localparam int M  = XLEN - 1;

    logic [SW-1:0] shamt;

    assign shamt = b[SW-1:0];

    // Result select; NOP and unknown codes retire as 0 without a write
    always_comb begin
        value = '0;
        wr_en = 1'b1;
        unique case (op)
            ALU_ADD: value = a + b;
            ALU_SUB: value = a - b;
            ALU_AND: value = a & b;
            ALU_ORR: value = a | b;
            ALU_EOR: value = a ^ b;
            ALU_NEG: value = '0 - a;
            ALU_CMP: begin
                value = a - b;
                wr_en = 1'b0;
            end
            ALU_LSL: value = a << shamt;
            ALU_LSR: value = a >> shamt;
            ALU_ASR: value = $unsigned($signed(a) >>> shamt);
            ALU_MOV: value = b;
            default: begin
                value = '0;
                wr_en = 1'b0;
            end
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic c;
    logic v;

    // Carry is no-borrow on subtracts; logic ops clear C and V
    always_comb begin
        c = 1'b0;
        v = 1'b0;
        unique case (op)
            ALU_ADD: begin
                c = (a[M] & b[M]) | ((a[M] | b[M]) & ~value[M]);
                v = (a[M] == b[M]) & (value[M] != a[M]);
            end
            ALU_SUB, ALU_CMP: begin
                c = (a >= b);
                v = (a[M] != b[M]) & (value[M] != a[M]);
            end
            ALU_NEG: begin
                c = (a == '0);
                v = a[M] & value[M];
            end
            default: begin
                c = 1'b0;
                v = 1'b0;
            end
        endcase
    end

    // Pack NZCV
    always_comb begin
        flags             = '0;
        flags[ALU_FLAG_N] = value[M];
        flags[ALU_FLAG_Z] = (value == '0);
        flags[ALU_FLAG_C] = c;
        flags[ALU_FLAG_V] = v;
    end
`endif

endmodule

// File: rtl/alu_pipe.sv
// LATENCY-stage pipelined integer ALU with ready/valid and flush.
// Define ALU_FLAGS_EN to add the pipelined out_flags (NZCV) port.
module alu_pipe
    import core_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int PHYS_W  = core_pkg::LOG2_PREGS,
    parameter int ROB_W   = 6,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  alu_op_e           issue_op,
    input  logic [PHYS_W-1:0] issue_dst_tag,
    input  logic [ROB_W-1:0]  issue_rob_tag,
    input  logic [XLEN-1:0]   issue_src1,
    input  logic [XLEN-1:0]   issue_src2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PHYS_W-1:0] out_tag,
    output logic [ROB_W-1:0]  out_rob_tag,
    output logic [XLEN-1:0]   out_value,
    output logic              out_wr_en,
    output logic [2:0]        busy_cnt
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]        out_flags
`endif
);

    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic [PHYS_W-1:0] dst_tag;
        logic [ROB_W-1:0]  rob_tag;
        logic [XLEN-1:0]   value;
`ifdef ALU_FLAGS_EN
        logic [3:0]        flags;
`endif
    } stage_t;

    stage_t          st [LATENCY];
    stage_t          nxt;
    logic            stall;
    logic [XLEN-1:0] ex_value;
    logic            ex_wr_en;
`ifdef ALU_FLAGS_EN
    logic [3:0]      ex_flags;
`endif

    alu_exec_comb #(
        .XLEN (XLEN)
    ) u_exec (
        .op    (issue_op),
        .a     (issue_src1),
        .b     (issue_src2),
        .value (ex_value),
        .wr_en (ex_wr_en)
`ifdef ALU_FLAGS_EN
        ,
        .flags (ex_flags)
`endif
    );

    // A waiting result that the CDB has not granted freezes the pipe
    assign stall       = st[LATENCY-1].valid & ~out_ready;
    assign issue_ready = ~stall;

    // Stage-1 capture bundle built from the issue port
    always_comb begin
        nxt         = '0;
        nxt.valid   = issue_valid;
        nxt.wr_en   = ex_wr_en;
        nxt.dst_tag = issue_dst_tag;
        nxt.rob_tag = issue_rob_tag;
        nxt.value   = ex_value;
`ifdef ALU_FLAGS_EN
        nxt.flags   = ex_flags;
`endif
    end

    // Stage registers: flush beats stall, stall holds every stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                st[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                st[i].valid <= 1'b0;
            end
        end else if (!stall) begin
            st[0] <= nxt;
            for (int i = 1; i < LATENCY; i++) begin
                st[i] <= st[i-1];
            end
        end
    end

    // Occupancy is the population count of stage valids
    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < LATENCY; i++) begin
            busy_cnt = busy_cnt + {2'b00, st[i].valid};
        end
    end

    assign out_valid   = st[LATENCY-1].valid;
    assign out_tag     = st[LATENCY-1].dst_tag;
    assign out_rob_tag = st[LATENCY-1].rob_tag;
    assign out_value   = st[LATENCY-1].value;
    assign out_wr_en   = st[LATENCY-1].wr_en;
`ifdef ALU_FLAGS_EN
    assign out_flags   = st[LATENCY-1].flags;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (main LATENCY=2, plus 1 and 4).
// Build with ALU_FLAGS_EN defined to also check NZCV.
`timescale 1ns/1ps
module tb_alu_pipe;
    import core_pkg::*;

    localparam int PW  = LOG2_PREGS;
    localparam int RW  = 6;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          flush = 1'b0;
    logic          issue_valid = 1'b0;
    logic [3:0]    op_bits = 4'd0;
    alu_op_e       issue_op;
    logic [PW-1:0] issue_dst_tag = '0;
    logic [RW-1:0] issue_rob_tag = '0;
    logic [31:0]   issue_src1 = '0;
    logic [31:0]   issue_src2 = '0;
    logic          out_ready = 1'b1;

    logic          issue_ready, out_valid, out_wr_en;
    logic [PW-1:0] out_tag;
    logic [RW-1:0] out_rob_tag;
    logic [31:0]   out_value;
    logic [2:0]    busy_cnt;

    logic          l1_ir, l1_ov, l1_we, l4_ir, l4_ov, l4_we;
    logic [PW-1:0] l1_tag, l4_tag;
    logic [RW-1:0] l1_rob, l4_rob;
    logic [31:0]   l1_val, l4_val;
    logic [2:0]    l1_busy, l4_busy;
`ifdef ALU_FLAGS_EN
    logic [3:0]    out_flags, l1_fl, l4_fl;
`endif

    assign issue_op = alu_op_e'(op_bits);

    always #5 clk = ~clk;

    alu_pipe #(.XLEN(32), .PHYS_W(PW), .ROB_W(RW), .LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_dst_tag(issue_dst_tag),
        .issue_rob_tag(issue_rob_tag),
        .issue_src1(issue_src1), .issue_src2(issue_src2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .out_rob_tag(out_rob_tag),
        .out_value(out_value), .out_wr_en(out_wr_en),
        .busy_cnt(busy_cnt)
`ifdef ALU_FLAGS_EN
        , .out_flags(out_flags)
`endif
    );

    alu_pipe #(.XLEN(32), .PHYS_W(PW), .ROB_W(RW), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(l1_ir),
        .issue_op(issue_op), .issue_dst_tag(issue_dst_tag),
        .issue_rob_tag(issue_rob_tag),
        .issue_src1(issue_src1), .issue_src2(issue_src2),
        .out_valid(l1_ov), .out_ready(1'b1),
        .out_tag(l1_tag), .out_rob_tag(l1_rob),
        .out_value(l1_val), .out_wr_en(l1_we),
        .busy_cnt(l1_busy)
`ifdef ALU_FLAGS_EN
        , .out_flags(l1_fl)
`endif
    );

    alu_pipe #(.XLEN(32), .PHYS_W(PW), .ROB_W(RW), .LATENCY(4)) dut_l4 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(l4_ir),
        .issue_op(issue_op), .issue_dst_tag(issue_dst_tag),
        .issue_rob_tag(issue_rob_tag),
        .issue_src1(issue_src1), .issue_src2(issue_src2),
        .out_valid(l4_ov), .out_ready(1'b1),
        .out_tag(l4_tag), .out_rob_tag(l4_rob),
        .out_value(l4_val), .out_wr_en(l4_we),
        .busy_cnt(l4_busy)
`ifdef ALU_FLAGS_EN
        , .out_flags(l4_fl)
`endif
    );

    typedef struct {
        logic [PW-1:0] tag;
        logic [RW-1:0] rob;
        logic [31:0]   val;
        logic          we;
        logic [3:0]    fl;
        int            age;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic stall_prev = 1'b0;
    logic [PW+RW+33:0] prev_f = '0;
    logic [3:0] prev_fl = '0;

    function automatic logic ovf(input longint r);
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    function automatic exp_t ref_op(input logic [3:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
        exp_t e;
        longint sa, sb;
        logic [32:0] w;
        int sh;
        logic c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        c = 1'b0;
        v = 1'b0;
        e.tag = '0;
        e.rob = '0;
        e.age = 0;
        e.we = 1'b1;
        e.val = '0;
        case (op)
            ALU_ADD: begin
                e.val = a + b;
                w = {1'b0, a} + {1'b0, b};
                c = w[32];
                v = ovf(sa + sb);
            end
            ALU_SUB, ALU_CMP: begin
                e.val = a - b;
                c = (a >= b);
                v = ovf(sa - sb);
                if (op == ALU_CMP) e.we = 1'b0;
            end
            ALU_AND: e.val = a & b;
            ALU_ORR: e.val = a | b;
            ALU_EOR: e.val = a ^ b;
            ALU_NEG: begin
                e.val = 32'(-sa);
                c = (a == 32'd0);
                v = ovf(-sa);
            end
            ALU_LSL: e.val = a << sh;
            ALU_LSR: e.val = a >> sh;
            ALU_ASR: e.val = 32'(sa >>> sh);
            ALU_MOV: e.val = b;
            default: begin
                e.val = '0;
                e.we = 1'b0;
            end
        endcase
        e.fl = {e.val[31], e.val == 32'd0, c, v};
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            4: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        issue_valid   = v;
        op_bits       = op;
        issue_src1    = a;
        issue_src2    = b;
        issue_dst_tag = PW'($urandom);
        issue_rob_tag = RW'($urandom);
    endtask

    task automatic step();
        logic stall, acc, hs, ev;
        exp_t e;
        #1;
        stall = out_valid && !out_ready;
        acc = issue_valid && issue_ready;
        hs = out_valid && out_ready;
        checks++;
        if (issue_ready !== !stall) begin
            errors++;
            $display("FAIL issue_ready got %b want %b", issue_ready, !stall);
        end
        if (stall_prev) begin
            checks++;
            if ({out_valid, out_tag, out_rob_tag, out_value, out_wr_en} !== prev_f) begin
                errors++;
                $display("FAIL stable got %h want %h",
                    {out_valid, out_tag, out_rob_tag, out_value, out_wr_en}, prev_f);
            end
`ifdef ALU_FLAGS_EN
            checks++;
            if (out_flags !== prev_fl) begin
                errors++;
                $display("FAIL stable_flags got %h want %h", out_flags, prev_fl);
            end
`endif
        end
        if (hs) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL spurious got val %h want none", out_value);
            end else begin
                e = q.pop_front();
                if ({out_tag, out_rob_tag, out_value, out_wr_en} !==
                    {e.tag, e.rob, e.val, e.we}) begin
                    errors++;
                    $display("FAIL result got %h/%h/%h/%b want %h/%h/%h/%b",
                        out_tag, out_rob_tag, out_value, out_wr_en,
                        e.tag, e.rob, e.val, e.we);
                end
`ifdef ALU_FLAGS_EN
                checks++;
                if (out_flags !== e.fl) begin
                    errors++;
                    $display("FAIL flags got %b want %b", out_flags, e.fl);
                end
`endif
            end
        end
        if (!stall) begin
            foreach (q[i]) q[i].age++;
        end
        if (acc) begin
            e = ref_op(op_bits, issue_src1, issue_src2);
            e.tag = issue_dst_tag;
            e.rob = issue_rob_tag;
            e.age = 1;
            q.push_back(e);
        end
        if (flush) q.delete();
        stall_prev = stall && !flush;
        prev_f = {out_valid, out_tag, out_rob_tag, out_value, out_wr_en};
`ifdef ALU_FLAGS_EN
        prev_fl = out_flags;
`endif
        @(posedge clk);
        #1;
        checks++;
        if (busy_cnt !== 3'(q.size())) begin
            errors++;
            $display("FAIL busy_cnt got %0d want %0d", busy_cnt, q.size());
        end
        ev = (q.size() > 0) && (q[0].age == LAT);
        checks++;
        if (out_valid !== ev) begin
            errors++;
            $display("FAIL out_valid got %b want %b", out_valid, ev);
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_tag, out_rob_tag, out_value, out_wr_en, busy_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outs got %h want 0",
                {out_valid, out_tag, out_rob_tag, out_value, out_wr_en, busy_cnt});
        end
`ifdef ALU_FLAGS_EN
        checks++;
        if (out_flags !== 4'd0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0", out_flags);
        end
`endif
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", issue_ready);
        end
    endtask

    task automatic test_latency();
        int lat1, lat4;
        logic [31:0] v1, v4;
        lat1 = -1;
        lat4 = -1;
        v1 = '0;
        v4 = '0;
        out_ready = 1'b1;
        drive(1'b1, ALU_ADD, 32'h1234, 32'h1111);
        step();
        drive(1'b0, ALU_NOP, 32'h0, 32'h0);
        for (int n = 1; n <= 8; n++) begin
            if (l1_ov && lat1 < 0) begin
                lat1 = n;
                v1 = l1_val;
            end
            if (l4_ov && lat4 < 0) begin
                lat4 = n;
                v4 = l4_val;
            end
            step();
        end
        checks++;
        if (lat1 != 1 || v1 !== 32'h2345) begin
            errors++;
            $display("FAIL lat1 got %0d/%h want 1/2345", lat1, v1);
        end
        checks++;
        if (lat4 != 4 || v4 !== 32'h2345) begin
            errors++;
            $display("FAIL lat4 got %0d/%h want 4/2345", lat4, v4);
        end
    endtask

    task automatic test_arith();
        out_ready = 1'b1;
        drive(1'b1, ALU_ADD, 32'h7FFFFFFF, 32'h1);
        step();
        drive(1'b1, ALU_SUB, 32'd5, 32'd7);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_value !== 32'h80000000 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_ovf got %b/%h/%b want 1/80000000/1",
                out_valid, out_value, issue_ready);
        end
`ifdef ALU_FLAGS_EN
        checks++;
        if (out_flags !== 4'b1001) begin
            errors++;
            $display("FAIL add_flags got %b want 1001", out_flags);
        end
`endif
        drive(1'b0, ALU_NOP, 32'h0, 32'h0);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_value !== 32'hFFFFFFFE) begin
            errors++;
            $display("FAIL sub got %b/%h want 1/fffffffe", out_valid, out_value);
        end
`ifdef ALU_FLAGS_EN
        checks++;
        if (out_flags !== 4'b1000) begin
            errors++;
            $display("FAIL sub_flags got %b want 1000", out_flags);
        end
`endif
        step();
    endtask

    task automatic test_shift();
        drive(1'b1, ALU_ASR, 32'h80000010, 32'd4);
        step();
        drive(1'b1, ALU_LSL, 32'h10, 32'h21);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_value !== 32'hF8000001) begin
            errors++;
            $display("FAIL asr got %b/%h want 1/f8000001", out_valid, out_value);
        end
        drive(1'b0, ALU_NOP, 32'h0, 32'h0);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_value !== 32'h20) begin
            errors++;
            $display("FAIL lsl got %b/%h want 1/20", out_valid, out_value);
        end
        step();
    endtask

    task automatic test_cmp();
        drive(1'b1, ALU_CMP, 32'd3, 32'd3);
        step();
        drive(1'b0, ALU_NOP, 32'h0, 32'h0);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_wr_en !== 1'b0 || out_value !== 32'h0) begin
            errors++;
            $display("FAIL cmp got %b/%b/%h want 1/0/0", out_valid, out_wr_en, out_value);
        end
`ifdef ALU_FLAGS_EN
        checks++;
        if (out_flags !== 4'b0110) begin
            errors++;
            $display("FAIL cmp_flags got %b want 0110", out_flags);
        end
`endif
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, ALU_ADD, 32'd1, 32'd2);
        step();
        drive(1'b1, ALU_EOR, 32'hF0F0, 32'h0FF0);
        step();
        drive(1'b1, ALU_MOV, 32'h0, 32'hC0FFEE);
        for (int n = 0; n < 4; n++) begin
            step();
            checks++;
            if (busy_cnt !== 3'd2 || issue_ready !== 1'b0 || out_value !== 32'd3) begin
                errors++;
                $display("FAIL bp_hold got %0d/%b/%h want 2/0/3",
                    busy_cnt, issue_ready, out_value);
            end
        end
        out_ready = 1'b1;
        step();
        drive(1'b0, ALU_NOP, 32'h0, 32'h0);
        repeat (LAT + 2) step();
        checks++;
        if (busy_cnt !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got %0d/%b want 0/0", busy_cnt, out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        drive(1'b1, ALU_ADD, 32'd10, 32'd20);
        step();
        drive(1'b1, ALU_SUB, 32'd100, 32'd1);
        step();
        checks++;
        if (busy_cnt !== 3'd2) begin
            errors++;
            $display("FAIL pre_flush got %0d want 2", busy_cnt);
        end
        flush = 1'b1;
        drive(1'b1, ALU_MOV, 32'h0, 32'hDEADBEEF);
        step();
        flush = 1'b0;
        drive(1'b0, ALU_NOP, 32'h0, 32'h0);
        checks++;
        if (busy_cnt !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush got %0d/%b want 0/0", busy_cnt, out_valid);
        end
        for (int n = 0; n < LAT + 2; n++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_drop got %b/%h want 0", out_valid, out_value);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        drive(1'b1, ALU_ADD, 32'd7, 32'd8);
        step();
        drive(1'b1, ALU_ORR, 32'h100, 32'h1);
        step();
        drive(1'b0, ALU_NOP, 32'h0, 32'h0);
        step();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_tag, out_rob_tag, out_value, out_wr_en, busy_cnt} !== '0) begin
            errors++;
            $display("FAIL async_rst got %h want 0",
                {out_valid, out_tag, out_rob_tag, out_value, out_wr_en, busy_cnt});
        end
        q.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        checks++;
        if (issue_ready !== 1'b1 || busy_cnt !== 3'd0) begin
            errors++;
            $display("FAIL rst_release got %b/%0d want 1/0", issue_ready, busy_cnt);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                  pick(), pick());
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 31) == 0);
            step();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, ALU_NOP, 32'h0, 32'h0);
        repeat (LAT + 2) step();
        checks++;
        if (busy_cnt !== 3'd0) begin
            errors++;
            $display("FAIL rand_drain got %0d want 0", busy_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_arith();
        test_shift();
        test_cmp();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised successor to the single-cycle integer ALU: a LATENCY-stage pipelined execution unit between the integer reservation station and the CDB arbiter.
- Adds ready/valid handshake on both sides and backpressure from the CDB grant.
- Adds a pipeline flush for branch mispredicts, an arithmetic shift, and an explicit register-write qualifier.
- Optionally produces NZCV flags.

Parameters:
XLEN, 32, datapath width (power of two, 16..64)
PHYS_W, core_pkg::LOG2_PREGS, physical register tag width
ROB_W, 6, ROB index width
LATENCY, 2, pipeline depth in cycles, issue to out_valid (1..4)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  kill all in-flight ops (mispredict/exception)
issue_valid  in  1  op presented
issue_ready  out  1  unit accepts op this cycle
issue_op  in  4  alu_op_e operation
issue_dst_tag  in  PHYS_W  destination physical register
issue_rob_tag  in  ROB_W  ROB index
issue_src1  in  XLEN  operand A
issue_src2  in  XLEN  operand B (register or immediate, already muxed)
out_valid  out  1  result available to CDB arbiter
out_ready  in  1  CDB grant
out_tag  out  PHYS_W  destination tag
out_rob_tag  out  ROB_W  ROB index
out_value  out  XLEN  result
out_wr_en  out  1  result writes register file (0 for CMP)
out_flags  out  4  NZCV; present only with ALU_FLAGS_EN
busy_cnt  out  3  number of valid ops in pipeline, 0..LATENCY

Behaviour:
- Reset (reset_n low, async): all stage valids 0.
  - out_valid=0, out_tag=0, out_rob_tag=0, out_value=0, out_wr_en=0, out_flags=0, busy_cnt=0.
  - issue_ready=1 once reset_n is high.
  - Reset mid-operation discards every in-flight op.
- Compute: result is computed combinationally from issue inputs and captured in stage 1. Stages 2..LATENCY are pure delay registers.
- Accept: an op is accepted when issue_valid & issue_ready. It appears on out_valid exactly LATENCY cycles later if there is no stall.
- Stall: stall = out_valid & ~out_ready.
  - issue_ready = ~stall (global stall, no bubble collapsing).
  - On stall, all stages hold. Output fields stay stable while out_valid=1 and out_ready=0.
- Handoff: out_valid & out_ready in the same cycle as a new accept streams at full throughput, 1 op/cycle.
- Flush: all stage valids are cleared on the next edge. An issue in the same cycle as flush is dropped. flush has priority over stall. issue_ready is unaffected by flush.
- busy_cnt: count of set stage valids.
  - +1 on accept, -1 on out handshake, both in the same cycle gives net 0.
  - Cleared to 0 by flush.
- Operations (alu_op_e), shifts use src2[$clog2(XLEN)-1:0]:
  - ADD: a+b, SUB: a-b, AND, ORR, EOR.
  - NEG: 0-a.
  - CMP: a-b with out_wr_en=0.
  - LSL: logical left shift. LSR: logical right shift. ASR: arithmetic right shift (sign-filled).
  - MOV: b.
  - NOP and undefined codes: accepted and retired with value 0 and out_wr_en=0.
- Arithmetic: XLEN-bit wrap-around, no exceptions.

Optional Feature:
ALU_FLAGS_EN:
- Defined: out_flags port exists and is pipelined with the result.
  - N = result MSB, Z = (result == 0).
  - ADD: C = carry out, V = signed overflow.
  - SUB/CMP/NEG: C = no-borrow (ARM convention), V = signed overflow.
  - Logic, shift, MOV: C=0, V=0.
- Undefined: port absent, no flag logic.

Decomposition:
- core_pkg: alu_op_e (4-bit enum), ALU_FLAG_N/Z/C/V bit indices, alu_stage_t packed struct {valid, op-derived wr_en, dst_tag, rob_tag, value, flags}.
- Sub-module alu_exec_comb: pure combinational op/flag evaluator.
- alu_pipe holds the stage registers, handshake, flush and counter.

Test Plan:
- Back-to-back ADD 0x7FFFFFFF+1, then SUB 5-7, LATENCY=2, out_ready=1 -> out_value 0x80000000 at cycle+2 (flags N=1, V=1), then 0xFFFFFFFE at cycle+3 (C=0); issue_ready stays 1.
- ASR 0x80000010 by 4, and LSL by src2=0x21 (shamt 1) -> 0xF8000001, then 0x00000020 with 0x10 as src1.
- CMP 3,3 -> out_wr_en=0, value 0, Z=1, C=1.
- Backpressure: 3 ops issued, out_ready=0 for 4 cycles -> out fields stable, issue_ready=0 from first out_valid, busy_cnt=2; release -> ops drain in order, no loss or duplication.
- Flush with busy_cnt=2 and simultaneous issue -> next cycle busy_cnt=0, out_valid=0, dropped op never appears.
- Assert reset_n low mid-stall -> all outputs 0 asynchronously, issue_ready=1 after release; sweep LATENCY=1 and 4 for latency check.
